// File: rtl/result_packer.sv
// result_packer: packs DATA_W-bit ALU results into MEM_WORD_SIZE-bit memory words.
// Ports: clk_i/rst_i (sync, active-high), result_* (in, valid/ready), flush_i, word_* (out, valid/ready).
module result_packer #(
    parameter int DATA_W        = 32,
    parameter int MEM_WORD_SIZE = 64,
    parameter bit LSB_FIRST     = 1'b1
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic [DATA_W-1:0]        result_i,
    input  logic                     result_valid_i,
    output logic                     result_ready_o,
    input  logic                     flush_i,
    output logic [MEM_WORD_SIZE-1:0] word_o,
    output logic [MEM_WORD_SIZE/DATA_W-1:0] word_mask_o,
    output logic                     word_valid_o,
    input  logic                     word_ready_i
);

    localparam int LANES = MEM_WORD_SIZE / DATA_W;
    localparam int PTR_W = $clog2(LANES);
    localparam logic [PTR_W-1:0] LAST = PTR_W'(LANES - 1);

    if ((MEM_WORD_SIZE % DATA_W) != 0 || LANES < 2) begin : g_bad_cfg
        $error("result_packer: MEM_WORD_SIZE must be a multiple (>=2x) of DATA_W");
    end

    typedef enum logic {
        FILL = 1'b0,
        HOLD = 1'b1
    } state_t;

    state_t                   state_q, state_d;
    logic [MEM_WORD_SIZE-1:0] buf_q, buf_d;
    logic [LANES-1:0]         mask_q, mask_d;
    logic [PTR_W-1:0]         ptr_q, ptr_d;
    int                       lane;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= FILL;
            buf_q   <= '0;
            mask_q  <= '0;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            buf_q   <= buf_d;
            mask_q  <= mask_d;
            ptr_q   <= ptr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        buf_d   = buf_q;
        mask_d  = mask_q;
        ptr_d   = ptr_q;
        lane    = 0;
        unique case (state_q)
            FILL: begin
                if (result_valid_i) begin
                    // Logical lane order is fixed; only the physical slot flips.
                    lane = LSB_FIRST ? int'(ptr_q) : int'(LAST - ptr_q);
                    buf_d[lane*DATA_W +: DATA_W] = result_i;
                    mask_d[ptr_q] = 1'b1;
                    ptr_d = ptr_q + PTR_W'(1);
                    if (ptr_q == LAST) begin
                        state_d = HOLD;
                        ptr_d   = '0;
                    end
                end
                // A flush only emits if the word would hold at least one
                // result; when the accept also completes the word this
                // merges into the single full-word emission above.
                if (flush_i && (result_valid_i || ptr_q != '0)) begin
                    state_d = HOLD;
                    ptr_d   = '0;
                end
            end
            HOLD: begin
                if (word_ready_i) begin
                    state_d = FILL;
                    buf_d   = '0;
                    mask_d  = '0;
                    ptr_d   = '0;
                end
            end
            default: state_d = FILL;
        endcase
    end

    assign word_o         = buf_q;
    assign word_mask_o    = mask_q;
    assign word_valid_o   = (state_q == HOLD);
    assign result_ready_o = (state_q == FILL);

endmodule

// File: doc/result_packer.md
Name: result_packer

Overview:
- Parametrised packing buffer that collects DATA_W-bit ALU results into MEM_WORD_SIZE-bit memory words.
- Replaces the single-bit loc_sel placement with an internal lane pointer that advances automatically.
- Adds valid/ready handshakes on both sides, an explicit flush for partial words, and a selectable lane order.
- Sits between the ALU result path and the memory write controller.

Parameters:
- DATA_W, 32, width of one result; MEM_WORD_SIZE must be an integer multiple of it (elaboration error otherwise).
- MEM_WORD_SIZE, 64, width of the packed output word.
- LANES, MEM_WORD_SIZE/DATA_W, derived localparam; number of result slots per word, must be >= 2.
- LSB_FIRST, 1, 1 = first result lands in the lowest slot; 0 = first result lands in the highest slot.

Ports:
- clk_i  in  1  clock; all state updates on posedge.
- rst_i  in  1  synchronous active-high reset.
- result_i  in  DATA_W  result from ALU.
- result_valid_i  in  1  result_i is valid this cycle.
- result_ready_o  out  1  block can accept a result this cycle.
- flush_i  in  1  request to emit the current partial word.
- word_o  out  MEM_WORD_SIZE  packed output word.
- word_mask_o  out  LANES  bit k = logical lane k holds a valid result.
- word_valid_o  out  1  word_o / word_mask_o are valid.
- word_ready_i  in  1  downstream accepts the word.

Behaviour:
- Interface: one clock, clk_i; reset rst_i is synchronous and active-high.
- Reset: on a posedge with rst_i=1, internal buffer and mask clear to 0, lane pointer clears to 0, state goes to FILL.
- Reset values of outputs: word_o=0, word_mask_o=0, word_valid_o=0, result_ready_o=1.
- Reset mid-operation discards any partial or held word with no output.
- States:
  - FILL: result_ready_o=1, word_valid_o=0.
  - HOLD: result_ready_o=0, word_valid_o=1.
- Accept: in FILL, when result_valid_i=1, result_i is written to logical lane ptr, mask[ptr] is set, and ptr increments.
- Lane placement:
  - LSB_FIRST=1: logical lane k occupies bits [k*DATA_W +: DATA_W].
  - LSB_FIRST=0: logical lane k occupies bits [(LANES-1-k)*DATA_W +: DATA_W].
- Full word: when the accepted result fills lane LANES-1, the next state is HOLD. word_valid_o rises the cycle after the last accept (1-cycle latency), and ptr wraps to 0.
- Flush:
  - In FILL with ptr>0 and flush_i=1, the next state is HOLD with the partial word.
  - Unfilled lanes read 0; their mask bits are 0.
  - If ptr wraps to 0 on that same edge, the flush was already satisfied by the full word.
- Flush with ptr==0 and no accept that cycle is ignored (no empty words are ever emitted).
- Simultaneous accept + flush in FILL: the result is written first, then the word (including that result) is emitted. If that accept completes the word, exactly one full word is emitted and the flush is consumed.
- Flush asserted in HOLD is ignored; it is not sticky.
- Result handshake: result_valid_i while result_ready_o=0 is not accepted. The upstream source must hold the result.
- Drain: in HOLD, word_o and word_mask_o stay stable while word_valid_o=1 and word_ready_i=0.
- On word_valid_o & word_ready_i, the next state is FILL. Buffer and mask clear to 0, ptr=0, and result_ready_o=1 the following cycle. There is no same-cycle refill (one bubble per word).
- Throughput: at most LANES results per LANES+1 cycles.
- word_ready_i is ignored in FILL.

Test Plan (DATA_W=32, MEM_WORD_SIZE=64, LANES=2):
- Reset then idle: word_valid_o=0, result_ready_o=1, word_o=0, word_mask_o=2'b00.
- LSB_FIRST=1, accept 32'hAAAA_0001 then 32'hBBBB_0002 with word_ready_i=1:
  - one cycle later, word_valid_o=1, word_o=64'hBBBB_0002_AAAA_0001, mask=2'b11;
  - next cycle, result_ready_o=1.
- LSB_FIRST=0, same stimulus -> word_o=64'hAAAA_0001_BBBB_0002, mask=2'b11.
- Accept 32'h1234_5678, then flush_i=1 -> word_o=64'h0000_0000_1234_5678, mask=2'b01. A flush with ptr==0 produces no word.
- Fill a word with word_ready_i=0 for 5 cycles:
  - word_o stays stable and result_ready_o=0;
  - result_valid_i pulses are not accepted;
  - flush_i pulses are ignored;
  - after word_ready_i=1, the next word starts at lane 0.
- Accept one result, then assert rst_i mid-word -> outputs return to reset values; the next two results form a clean word with mask=2'b11.
